// File: rtl/context_loader_pkg.sv
// Shared definitions for the context loader and the CCU: FSM state encoding
// and the bit positions of the {uncond,cond,offset} branch-context entry fields.
package context_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_LOAD  = 2'd2
  } ld_state_e;

  // Entry layout for an address width aw: offset in [aw-1:0], then cond, then uncond.
  localparam int ENT_OFFSET_LSB = 0;

  function automatic int ent_cond_bit(input int aw);
    return aw;
  endfunction

  function automatic int ent_uncond_bit(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/context_loader_if.sv
// Host/CCU-facing bundle of the context loader. The slave modport is the loader itself.
// CHECKSUM_O exists only when CONTEXT_LOADER_CHECKSUM_EN is defined.
interface context_loader_if #(parameter int AW = 8);
  logic          CFG_VALID_I;
  logic          CFG_READY_O;
  logic [AW-1:0] CFG_BASE_I;
  logic [AW:0]   CFG_LEN_I;
  logic [AW-1:0] CFG_ENTRY_I;
  logic          DAT_VALID_I;
  logic          DAT_READY_O;
  logic [AW+1:0] DAT_I;
  logic          ABORT_I;
  logic          CCU_EN_O;
  logic          CCU_WR_EN_O;
  logic [AW-1:0] CCU_ADDR_O;
  logic [AW+1:0] CCU_DATA_O;
  logic          CCU_LOAD_EN_O;
  logic          BUSY_O;
  logic          DONE_O;
  logic          ERR_O;
`ifdef CONTEXT_LOADER_CHECKSUM_EN
  logic [AW+1:0] CHECKSUM_O;
`endif

  modport master (
`ifdef CONTEXT_LOADER_CHECKSUM_EN
    input  CHECKSUM_O,
`endif
    output CFG_VALID_I, CFG_BASE_I, CFG_LEN_I, CFG_ENTRY_I,
    output DAT_VALID_I, DAT_I, ABORT_I,
    input  CFG_READY_O, DAT_READY_O,
    input  CCU_EN_O, CCU_WR_EN_O, CCU_ADDR_O, CCU_DATA_O, CCU_LOAD_EN_O,
    input  BUSY_O, DONE_O, ERR_O
  );

  modport slave (
`ifdef CONTEXT_LOADER_CHECKSUM_EN
    output CHECKSUM_O,
`endif
    input  CFG_VALID_I, CFG_BASE_I, CFG_LEN_I, CFG_ENTRY_I,
    input  DAT_VALID_I, DAT_I, ABORT_I,
    output CFG_READY_O, DAT_READY_O,
    output CCU_EN_O, CCU_WR_EN_O, CCU_ADDR_O, CCU_DATA_O, CCU_LOAD_EN_O,
    output BUSY_O, DONE_O, ERR_O
  );
endinterface

// File: rtl/context_loader_counter.sv
// Write pointer / remaining-entry pair for one context load; last flags the final entry.
module context_loader_counter #(
  parameter int AW = 8
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] ptr,
  output logic          last
);
  logic [AW:0] remaining;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= base;
      remaining <= len;
    end else if (step && remaining != '0) begin
      remaining <= remaining - 1'b1;
      // holding on the last entry keeps ptr from wrapping when base+len == 2**AW
      if (!last) ptr <= ptr + 1'b1;
    end
  end

  assign last = (remaining == (AW+1)'(1));
endmodule

// File: rtl/context_loader.sv
// Writes a host-supplied block of branch-context entries into CCU memory, then
// strobes LOAD_EN with the start address. Optional CHECKSUM_O: CONTEXT_LOADER_CHECKSUM_EN.
module context_loader
  import context_loader_pkg::*;
#(
  parameter int CONTEXT_ADDR_WIDTH    = 8,
  parameter int CONTEXT_MEMORY_LENGTH = 256
) (
  input logic             CLK_I,
  input logic             RST_N_I,
  context_loader_if.slave bus
);
  localparam int            AW    = CONTEXT_ADDR_WIDTH;
  localparam logic [AW+1:0] DEPTH = (AW+2)'(CONTEXT_MEMORY_LENGTH);

  ld_state_e     state_q, state_d;
  logic          cfg_ready, dat_ready, cfg_fire, dat_fire, desc_ok, accept, load_fire;
  logic [AW+1:0] span;
  logic [AW-1:0] ptr, entry_q;
  logic          last;
  logic          en_q, wr_en_q, load_en_q, done_q, err_q;
  logic [AW-1:0] addr_q;
  logic [AW+1:0] data_q;

  // range check is one bit wider than base+len can reach, so it never wraps
  assign span    = {2'b00, bus.CFG_BASE_I} + {1'b0, bus.CFG_LEN_I};
  assign desc_ok = (bus.CFG_LEN_I != '0) && (span <= DEPTH);
  assign cfg_fire = bus.CFG_VALID_I && cfg_ready;
  assign dat_fire = bus.DAT_VALID_I && dat_ready;
  assign accept   = cfg_fire && desc_ok;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_WRITE;
      ST_WRITE: if (bus.ABORT_I) state_d = ST_IDLE;
                else if (dat_fire && last) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    dat_ready = 1'b0;
    load_fire = 1'b0;
    case (state_q)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_WRITE: dat_ready = 1'b1;
      ST_LOAD:  load_fire = !bus.ABORT_I;
      default:  ;
    endcase
  end

  context_loader_counter #(.AW(AW)) u_cnt (
    .CLK_I   (CLK_I),
    .RST_N_I (RST_N_I),
    .load    (accept),
    .step    (dat_fire),
    .base    (bus.CFG_BASE_I),
    .len     (bus.CFG_LEN_I),
    .ptr     (ptr),
    .last    (last)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      en_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      load_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      entry_q   <= '0;
    end else begin
      wr_en_q   <= dat_fire;
      load_en_q <= load_fire;
      done_q    <= load_en_q;
      if (dat_fire) begin
        addr_q <= ptr;
        data_q <= bus.DAT_I;
      end else if (load_fire) begin
        addr_q <= entry_q;
      end
      if (cfg_fire) err_q <= !desc_ok;
      if (accept) begin
        en_q    <= 1'b0;
        entry_q <= bus.CFG_ENTRY_I;
      end else if (load_fire) begin
        en_q <= 1'b1;
      end
    end
  end

`ifdef CONTEXT_LOADER_CHECKSUM_EN
  logic [AW+1:0] csum_q;
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)     csum_q <= '0;
    else if (accept)  csum_q <= '0;
    else if (dat_fire) csum_q <= csum_q ^ bus.DAT_I;
  end
  assign bus.CHECKSUM_O = csum_q;
`endif

  assign bus.CFG_READY_O   = cfg_ready;
  assign bus.DAT_READY_O   = dat_ready;
  assign bus.BUSY_O        = (state_q != ST_IDLE);
  assign bus.CCU_EN_O      = en_q;
  assign bus.CCU_WR_EN_O   = wr_en_q;
  assign bus.CCU_ADDR_O    = addr_q;
  assign bus.CCU_DATA_O    = data_q;
  assign bus.CCU_LOAD_EN_O = load_en_q;
  assign bus.DONE_O        = done_q;
  assign bus.ERR_O         = err_q;
endmodule

// File: tb/tb_context_loader.sv
// Randomized + directed bench for context_loader (AW=4, 16 entries) against a
// transaction-level model: expected write list, load strobe, done pulse and CCU memory image.
module tb_context_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  context_loader_if #(.AW(AW)) bus();

  context_loader #(.CONTEXT_ADDR_WIDTH(AW), .CONTEXT_MEMORY_LENGTH(DEPTH)) dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // monitor: what the CCU would see on its write/load port
  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t           wr_q[$];
  int            load_n = 0, load_addr = 0, load_cyc = 0, done_n = 0, done_cyc = 0;
  logic [AW+1:0] ccu_mem [DEPTH];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.CCU_WR_EN_O) begin
        wr_q.push_back('{int'(bus.CCU_ADDR_O), int'(bus.CCU_DATA_O), cyc});
        ccu_mem[bus.CCU_ADDR_O] = bus.CCU_DATA_O;
      end
      if (bus.CCU_LOAD_EN_O) begin
        load_n++;
        load_addr = int'(bus.CCU_ADDR_O);
        load_cyc  = cyc;
      end
      if (bus.DONE_O) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  // reference state
  int mem_ref [DEPTH];
  int ents    [32];
  bit en_ref  = 1'b0;

  task automatic send_cfg(input int base, input int len, input int entry);
    bit ok = 1'b0;
    bus.CFG_VALID_I = 1'b1;
    bus.CFG_BASE_I  = AW'(base);
    bus.CFG_LEN_I   = (AW+1)'(len);
    bus.CFG_ENTRY_I = AW'(entry);
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); ok = bus.CFG_READY_O;
      @(posedge clk); #1;
    end
    bus.CFG_VALID_I = 1'b0;
    chk("cfg_accept", ok, 1);
  endtask

  task automatic send_dat(input int d, input bit gap, input bit abort);
    bit ok = 1'b0;
    if (gap) begin
      bus.DAT_VALID_I = 1'b0;
      @(posedge clk); #1;
    end
    bus.DAT_VALID_I = 1'b1;
    bus.DAT_I       = (AW+2)'(d);
    bus.ABORT_I     = abort;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); ok = bus.DAT_READY_O;
      @(posedge clk); #1;
    end
    bus.DAT_VALID_I = 1'b0;
    bus.ABORT_I     = 1'b0;
    chk("dat_accept", ok, 1);
  endtask

  // abort_at: -1 none, 0..len-1 with that entry's handshake, len in the cycle after the last
  task automatic run_txn(input int base, input int len, input int entry, input bit gaps,
                         input int abort_at);
    int w0 = wr_q.size();
    int l0 = load_n;
    int d0 = done_n;
    bit legal = (len > 0) && (base + len <= DEPTH);
    int n_wr = 0;
    bit complete;
    int n_obs;
    int csum = 0;
    send_cfg(base, len, entry);
    if (legal) begin
      n_wr = (abort_at >= 0 && abort_at < len) ? abort_at + 1 : len;
      for (int i = 0; i < n_wr; i++) send_dat(ents[i], gaps, i == abort_at);
      if (abort_at == len) begin
        bus.ABORT_I = 1'b1;
        @(posedge clk); #1;
        bus.ABORT_I = 1'b0;
      end
    end
    complete = legal && (abort_at < 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err", bus.ERR_O, !legal);
    chk("busy_idle", bus.BUSY_O, 0);
    n_obs = wr_q.size() - w0;
    chk("wr_cnt", n_obs, n_wr);
    for (int i = 0; i < n_obs && i < n_wr; i++) begin
      chk("wr_addr", wr_q[w0+i].addr, base + i);
      chk("wr_data", wr_q[w0+i].data, ents[i]);
      csum ^= ents[i];
      mem_ref[base+i] = ents[i];
    end
    if (n_obs > 1 && n_wr > 1)
      chk("wr_spacing", wr_q[$].cyc - wr_q[w0].cyc, (gaps ? 2 : 1) * (n_wr - 1));
    chk("load_cnt", load_n - l0, complete);
    chk("done_cnt", done_n - d0, complete);
    if (complete && n_obs > 0 && load_n > l0) begin
      chk("load_addr", load_addr, entry);
      chk("load_after_wr", load_cyc, wr_q[$].cyc + 1);
      chk("done_after_load", done_cyc, load_cyc + 1);
    end
    if (legal) en_ref = complete;
    chk("ccu_en", bus.CCU_EN_O, en_ref);
`ifdef CONTEXT_LOADER_CHECKSUM_EN
    if (legal) chk("checksum", bus.CHECKSUM_O, csum);
`endif
  endtask

  initial begin
    bus.CFG_VALID_I = 1'b0; bus.CFG_BASE_I = '0; bus.CFG_LEN_I = '0; bus.CFG_ENTRY_I = '0;
    bus.DAT_VALID_I = 1'b0; bus.DAT_I = '0; bus.ABORT_I = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem_ref[a] = -1;

    // reset values
    #12;
    chk("rst_wr_en", bus.CCU_WR_EN_O, 0);
    chk("rst_en", bus.CCU_EN_O, 0);
    chk("rst_load_en", bus.CCU_LOAD_EN_O, 0);
    chk("rst_misc", {bus.BUSY_O, bus.DONE_O, bus.ERR_O, bus.DAT_READY_O}, 0);
    chk("rst_addr_data", {bus.CCU_ADDR_O, bus.CCU_DATA_O}, 0);
    chk("rst_cfg_ready", bus.CFG_READY_O, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of a load
    send_cfg(0, 4, 0);
    send_dat(5, 0, 0);
    send_dat(6, 0, 0);
    chk("mid_busy", bus.BUSY_O, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", bus.CCU_WR_EN_O, 0);
    chk("mid_rst_outs", {bus.BUSY_O, bus.DONE_O, bus.ERR_O, bus.CCU_EN_O, bus.CCU_LOAD_EN_O}, 0);
    chk("mid_rst_addr_data", {bus.CCU_ADDR_O, bus.CCU_DATA_O}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en_ref = 1'b0;
    @(posedge clk); #1;

    // directed: back-to-back, then toggling valid
    ents[0] = 'h21; ents[1] = 'h02; ents[2] = 'h3F; ents[3] = 'h01;
    run_txn(3, 4, 3, 0, -1);
    run_txn(3, 4, 3, 1, -1);

    // out-of-range descriptor, then a legal one clears the error
    run_txn(14, 3, 0, 0, -1);
    ents[0] = 'h15;
    run_txn(0, 1, 0, 0, -1);

    // abort on the last handshake
    ents[0] = 'h21; ents[1] = 'h02; ents[2] = 'h3F; ents[3] = 'h01;
    run_txn(3, 4, 3, 0, 3);
    ents[0] = 'h0A;
    run_txn(9, 1, 9, 0, -1);

    // abort in idle is ignored
    bus.ABORT_I = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.ABORT_I = 1'b0;
    chk("idle_abort_busy", bus.BUSY_O, 0);
    chk("idle_abort_en", bus.CCU_EN_O, en_ref);

    // randomized descriptors
    for (int n = 0; n < 40; n++) begin
      int base, len, entry, r, abort_at;
      bit gaps;
      base = int'($urandom_range(0, DEPTH - 1));
      r    = int'($urandom_range(0, 9));
      if (r == 0)      len = 0;
      else if (r == 1) len = int'($urandom_range(DEPTH - base + 1, 31));
      else             len = int'($urandom_range(1, DEPTH - base));
      entry    = int'($urandom_range(0, DEPTH - 1));
      gaps     = 1'($urandom_range(0, 1));
      abort_at = ($urandom_range(0, 4) == 0 && len > 0) ? int'($urandom_range(0, len)) : -1;
      for (int i = 0; i < 32; i++) ents[i] = int'($urandom_range(0, 63));
      run_txn(base, len, entry, gaps, abort_at);
    end

    // final CCU memory image
    for (int a = 0; a < DEPTH; a++)
      if (mem_ref[a] >= 0) chk("mem_image", ccu_mem[a], mem_ref[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
